branch_predictor: RTL and testbench
===================================

# branch_predictor

Fetch-stage direction and target predictor for the MIPS32 core. It feeds the PC-select logic a predicted-taken flag and target for the current fetch PC. It learns from the per-branch outcome produced at resolution, using the same 3-bit branch code and taken result that the branch resolver emits. Storage is a direct-mapped table of 2-bit saturating counters plus a tagged target buffer, with two performance counters.

## Interface
- INDEX_BITS, 6, log2 of table entries (64 entries); index = PC[INDEX_BITS+1:2], tag = PC[31:INDEX_BITS+2]
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- fetchPC  in  32  PC currently being fetched
- predTaken  out  1  predict branch at fetchPC taken
- predTarget  out  32  predicted target; valid only when predTaken=1, 32'd0 otherwise
- updValid  in  1  resolution result present this cycle
- updPC  in  32  PC of resolved instruction
- updBranch  in  3  branch code of resolved instruction (0 none, 1 beq, 2 bne, 3 bgez, 4 bgtz, 5 blez, 6 bltz, 7 reserved)
- updTaken  in  1  resolved direction (resolver branchTaken)
- updTarget  in  32  resolved branch target
- updPredTaken  in  1  prediction originally given for this instruction (carried down the pipe)
- branchCount  out  32  number of conditional branches resolved
- mispredCount  out  32  number of direction mispredictions

## Operation
- Per entry: valid (1), tag (32-INDEX_BITS-2), target (32), ctr (2).
- Lookup (combinational): hit = valid[idx] & (tag[idx]==fetchPC tag); predTaken = hit & ctr[idx][1]; predTarget = predTaken ? target[idx] : 0.
- Update qualifies only when updValid=1 and updBranch in 1..6; codes 0 and 7 cause no state change and no counting.
- Qualified update, tag hit: ctr saturating increment if updTaken (max 3), saturating decrement otherwise (min 0). Target is written only when updTaken=1.
- Qualified update, tag miss or invalid: allocate entry, overwriting any existing one. Set valid=1, tag=updPC tag, target=updTarget, ctr=2'b10 if updTaken else 2'b01.
- branchCount += 1 on every qualified update.
- mispredCount += 1 on qualified update when updPredTaken != updTaken.
- Both counters wrap modulo 2^32 with no saturation.
- updPC[1:0] is ignored.

## Timing
- Prediction has zero latency: predTaken/predTarget follow fetchPC combinationally in the same cycle.
- Update is written at the rising edge of the cycle in which updValid=1. It is visible to lookups from the next cycle onward.
- Same-cycle read/write of one entry (fetchPC index == updPC index): lookup returns the pre-update contents, with no bypass.
- One update per cycle maximum. Each updValid=1 cycle is a distinct update; there is no handshake or backpressure.
- Reset (async, any time, including mid-update): all valid=0, ctr=2'b01, tag/target=0, branchCount=0, mispredCount=0.
  - Outputs during and after reset: predTaken=0, predTarget=0.
  - An update coincident with rst=1 is discarded.
- After rst deasserts, the first update is accepted on the next rising edge.

## Test plan
- Reset/cold: after rst, sweep fetchPC 0x00400000..0x004000FC -> predTaken=0 and predTarget=0 everywhere; branchCount=0 and mispredCount=0.
- Training: 2 updates for PC 0x00400010, updBranch=1, updTaken=1, updTarget=0x00400040, updPredTaken=0.
  - After update 1: ctr=2, so fetchPC 0x00400010 gives predTaken=1 and predTarget=0x00400040.
  - After update 2: ctr=3.
  - Counts: branchCount=2, mispredCount=2.
- Hysteresis: from ctr=3, one not-taken update (updPredTaken=1) -> still predTaken=1 (ctr=2), mispredCount+1. A second not-taken update -> predTaken=0 (ctr=1).
- Aliasing: entry trained at 0x00400010, then a taken update at 0x00400110 (same index, different tag), target 0x00400200.
  - Lookup at 0x00400010 -> predTaken=0.
  - Lookup at 0x00400110 -> predTaken=1, predTarget=0x00400200.
- Filtering and bypass:
  - Updates with updBranch=0 and updBranch=7 -> no table change and no count change.
  - Update and lookup of the same index in one cycle -> old prediction that cycle, new prediction the next cycle.
- Async reset mid-stream: assert rst between clock edges while updValid=1 -> outputs clear immediately, that update is lost, and counters read 0.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and resolution-side training signals for the branch predictor.
// The predictor is the slave side; the core pipeline is the master side.
interface branch_predictor_if;
  logic [31:0] fetchPC;
  logic        predTaken;
  logic [31:0] predTarget;
  logic        updValid;
  logic [31:0] updPC;
  logic [2:0]  updBranch;
  logic        updTaken;
  logic [31:0] updTarget;
  logic        updPredTaken;
  logic [31:0] branchCount;
  logic [31:0] mispredCount;

  modport master (
    output fetchPC, updValid, updPC, updBranch, updTaken, updTarget, updPredTaken,
    input  predTaken, predTarget, branchCount, mispredCount
  );

  modport slave (
    input  fetchPC, updValid, updPC, updBranch, updTaken, updTarget, updPredTaken,
    output predTaken, predTarget, branchCount, mispredCount
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit-counter direction predictor with a tagged target buffer.
// Lookup is combinational on fetchPC; training happens at the edge of a resolved branch.
module branch_predictor #(
  parameter int INDEX_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  branch_predictor_if.slave   bp
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = 32 - INDEX_BITS - 2;

  logic              valid_mem  [ENTRIES];
  logic [TAG_W-1:0]  tag_mem    [ENTRIES];
  logic [31:0]       target_mem [ENTRIES];
  logic [1:0]        ctr_mem    [ENTRIES];
  logic [31:0]       branch_cnt, mispred_cnt;

  logic [INDEX_BITS-1:0] f_idx, u_idx;
  logic [TAG_W-1:0]      f_tag, u_tag;
  logic                  f_hit, u_hit, u_qual;

  assign f_idx = bp.fetchPC[INDEX_BITS+1:2];
  assign f_tag = bp.fetchPC[31:INDEX_BITS+2];
  assign u_idx = bp.updPC[INDEX_BITS+1:2];
  assign u_tag = bp.updPC[31:INDEX_BITS+2];

  // Word-aligned PCs: the low two bits carry no information.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.fetchPC[1:0], bp.updPC[1:0]};

  // Reads see pre-update contents; no write-to-read bypass.
  assign f_hit         = valid_mem[f_idx] && (tag_mem[f_idx] == f_tag);
  assign bp.predTaken  = f_hit && ctr_mem[f_idx][1];
  assign bp.predTarget = bp.predTaken ? target_mem[f_idx] : 32'd0;

  assign u_hit  = valid_mem[u_idx] && (tag_mem[u_idx] == u_tag);
  assign u_qual = bp.updValid && (bp.updBranch != 3'd0) && (bp.updBranch != 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_mem[i]  <= 1'b0;
        tag_mem[i]    <= '0;
        target_mem[i] <= '0;
        ctr_mem[i]    <= 2'b01;
      end
    end else if (u_qual) begin
      if (u_hit) begin
        if (bp.updTaken) begin
          if (ctr_mem[u_idx] != 2'b11) ctr_mem[u_idx] <= ctr_mem[u_idx] + 2'd1;
          target_mem[u_idx] <= bp.updTarget;
        end else if (ctr_mem[u_idx] != 2'b00) begin
          ctr_mem[u_idx] <= ctr_mem[u_idx] - 2'd1;
        end
      end else begin
        // Allocation seeds the counter just on the resolved side of the threshold.
        valid_mem[u_idx]  <= 1'b1;
        tag_mem[u_idx]    <= u_tag;
        target_mem[u_idx] <= bp.updTarget;
        ctr_mem[u_idx]    <= bp.updTaken ? 2'b10 : 2'b01;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (u_qual) begin
      branch_cnt <= branch_cnt + 32'd1;
      if (bp.updPredTaken != bp.updTaken) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

  assign bp.branchCount  = branch_cnt;
  assign bp.mispredCount = mispred_cnt;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  branch_predictor_if bp();

  branch_predictor #(.INDEX_BITS(6)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One-cycle update pulse: drive at a falling edge, consumed at the next rising edge.
  task automatic upd(input logic [31:0] pc, input logic [2:0] br, input logic tk,
                     input logic [31:0] tgt, input logic pt);
    @(negedge clk);
    bp.updValid = 1'b1; bp.updPC = pc; bp.updBranch = br;
    bp.updTaken = tk; bp.updTarget = tgt; bp.updPredTaken = pt;
    @(negedge clk);
    bp.updValid = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    bp.fetchPC = pc;
    #1;
  endtask

  initial begin
    int bad;
    bp.fetchPC = 32'h0040_0010; bp.updValid = 1'b0; bp.updPC = '0;
    bp.updBranch = '0; bp.updTaken = 1'b0; bp.updTarget = '0; bp.updPredTaken = 1'b0;
    #1;
    chk("rst_pred", {31'd0, bp.predTaken}, 32'd0);
    chk("rst_tgt", bp.predTarget, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Cold sweep
    bad = 0;
    for (int a = 32'h0040_0000; a <= 32'h0040_00FC; a += 4) begin
      look(a);
      if (bp.predTaken !== 1'b0 || bp.predTarget !== 32'd0) bad++;
    end
    chk("cold_sweep", bad, 32'd0);
    chk("cold_bcnt", bp.branchCount, 32'd0);
    chk("cold_mcnt", bp.mispredCount, 32'd0);

    // Training
    upd(32'h0040_0010, 3'd1, 1'b1, 32'h0040_0040, 1'b0);
    look(32'h0040_0010);
    chk("train1_pred", {31'd0, bp.predTaken}, 32'd1);
    chk("train1_tgt", bp.predTarget, 32'h0040_0040);
    upd(32'h0040_0010, 3'd1, 1'b1, 32'h0040_0040, 1'b0);
    chk("train2_bcnt", bp.branchCount, 32'd2);
    chk("train2_mcnt", bp.mispredCount, 32'd2);

    // Hysteresis: 3 -> 2 still taken, 2 -> 1 not taken
    upd(32'h0040_0010, 3'd1, 1'b0, 32'h0040_0999, 1'b1);
    look(32'h0040_0010);
    chk("hyst1_pred", {31'd0, bp.predTaken}, 32'd1);
    chk("hyst1_tgt", bp.predTarget, 32'h0040_0040);
    chk("hyst1_mcnt", bp.mispredCount, 32'd3);
    upd(32'h0040_0010, 3'd1, 1'b0, 32'h0040_0999, 1'b1);
    look(32'h0040_0010);
    chk("hyst2_pred", {31'd0, bp.predTaken}, 32'd0);
    chk("hyst2_tgt", bp.predTarget, 32'd0);

    // Aliasing: retrain 0x10 to ctr=2, then allocate 0x110 over it
    upd(32'h0040_0010, 3'd1, 1'b1, 32'h0040_0040, 1'b0);
    look(32'h0040_0010);
    chk("alias_pre", {31'd0, bp.predTaken}, 32'd1);
    upd(32'h0040_0110, 3'd1, 1'b1, 32'h0040_0200, 1'b0);
    look(32'h0040_0010);
    chk("alias_old", {31'd0, bp.predTaken}, 32'd0);
    look(32'h0040_0110);
    chk("alias_new_pred", {31'd0, bp.predTaken}, 32'd1);
    chk("alias_new_tgt", bp.predTarget, 32'h0040_0200);
    chk("alias_bcnt", bp.branchCount, 32'd6);
    chk("alias_mcnt", bp.mispredCount, 32'd6);

    // Filtering: codes 0 and 7 must not train or count
    upd(32'h0040_0110, 3'd0, 1'b0, 32'h0, 1'b1);
    upd(32'h0040_0110, 3'd7, 1'b0, 32'h0, 1'b1);
    upd(32'h0040_0020, 3'd7, 1'b1, 32'h0040_0300, 1'b0);
    look(32'h0040_0110);
    chk("filt_keep", {31'd0, bp.predTaken}, 32'd1);
    look(32'h0040_0020);
    chk("filt_noalloc", {31'd0, bp.predTaken}, 32'd0);
    chk("filt_bcnt", bp.branchCount, 32'd6);
    chk("filt_mcnt", bp.mispredCount, 32'd6);

    // Same-cycle read/write of one entry: old value now, new value after the edge
    @(negedge clk);
    bp.updValid = 1'b1; bp.updPC = 32'h0040_0110; bp.updBranch = 3'd5;
    bp.updTaken = 1'b0; bp.updTarget = 32'h0; bp.updPredTaken = 1'b1;
    bp.fetchPC = 32'h0040_0110;
    #1;
    chk("bypass_old", {31'd0, bp.predTaken}, 32'd1);
    @(posedge clk);
    #1;
    bp.updValid = 1'b0;
    chk("bypass_new", {31'd0, bp.predTaken}, 32'd0);
    chk("bypass_bcnt", bp.branchCount, 32'd7);
    chk("bypass_mcnt", bp.mispredCount, 32'd7);

    // Correctly predicted bne allocates without a mispredict
    upd(32'h0040_0030, 3'd2, 1'b1, 32'h0040_0080, 1'b1);
    look(32'h0040_0030);
    chk("bne_pred", {31'd0, bp.predTaken}, 32'd1);
    chk("bne_tgt", bp.predTarget, 32'h0040_0080);
    chk("bne_bcnt", bp.branchCount, 32'd8);
    chk("bne_mcnt", bp.mispredCount, 32'd7);

    // Async reset between edges while an update is pending
    @(negedge clk);
    bp.updValid = 1'b1; bp.updPC = 32'h0040_0040; bp.updBranch = 3'd1;
    bp.updTaken = 1'b1; bp.updTarget = 32'h0040_0500; bp.updPredTaken = 1'b0;
    bp.fetchPC = 32'h0040_0030;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pred", {31'd0, bp.predTaken}, 32'd0);
    chk("arst_tgt", bp.predTarget, 32'd0);
    chk("arst_bcnt", bp.branchCount, 32'd0);
    chk("arst_mcnt", bp.mispredCount, 32'd0);
    @(negedge clk);
    bp.updValid = 1'b0;
    rst = 1'b0;
    look(32'h0040_0040);
    chk("arst_lost", {31'd0, bp.predTaken}, 32'd0);

    // First update after reset release is accepted
    upd(32'h0040_0040, 3'd6, 1'b1, 32'h0040_0500, 1'b0);
    look(32'h0040_0040);
    chk("post_pred", {31'd0, bp.predTaken}, 32'd1);
    chk("post_tgt", bp.predTarget, 32'h0040_0500);
    chk("post_bcnt", bp.branchCount, 32'd1);
    chk("post_mcnt", bp.mispredCount, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
